// File: rtl/axis_m_pkt_tx.sv
// AXI4-Stream byte transmitter: push FIFO, registered output stage, packet counter and sticky overflow.
// Build option AXIS_TX_STORE_FWD_EN: in IDLE, hold off until a whole packet (or a full FIFO) is buffered.
module axis_m_pkt_tx #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             m_axis_aclk,
  input  logic             m_axis_aresetn,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  output logic             wr_full,
  output logic             overflow,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [8:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q;
  logic              tvalid_q, tlast_q;
  logic [7:0]        tdata_q;
  logic [CNT_W-1:0]  pkt_count_q;
  logic [8:0]        head;
  logic              fifo_empty, push, load, hs, load_ok, idle_ok;

  assign wr_full    = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign push       = wr_en & ~wr_full;
  assign hs         = tvalid_q & m_axis_tready;
  assign load       = ~fifo_empty & (~tvalid_q | m_axis_tready) & load_ok;

`ifdef AXIS_TX_STORE_FWD_EN
  logic [AW:0] pkts_stored_q, pkts_stored_d;

  always_comb begin
    pkts_stored_d = pkts_stored_q;
    case ({push & wr_last, load & head[8]})
      2'b10:   pkts_stored_d = pkts_stored_q + 1'b1;
      2'b01:   pkts_stored_d = pkts_stored_q - 1'b1;
      default: pkts_stored_d = pkts_stored_q;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) pkts_stored_q <= '0;
    else                 pkts_stored_q <= pkts_stored_d;
  end

  // A packet longer than the FIFO can never be complete in it, so a full FIFO also releases IDLE.
  assign idle_ok = (pkts_stored_q != '0) | wr_full;
`else
  assign idle_ok = 1'b1;
`endif

  always_comb begin
    load_ok = idle_ok;
    if (state_q == SEND) load_ok = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == SEND);
    case (state_q)
      IDLE: if (load) state_d = SEND;
      SEND: if (hs && tlast_q && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge m_axis_aclk) begin
    if (push) mem[wr_ptr_q] <= {wr_last, wr_data};
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= 8'h00;
      tlast_q     <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wr_en && wr_full) overflow_q <= 1'b1;
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        tvalid_q <= 1'b1;
        tdata_q  <= head[7:0];
        tlast_q  <= head[8];
      end else if (hs) begin
        tvalid_q <= 1'b0;
      end
      if (hs && tlast_q) pkt_count_q <= pkt_count_q + 1'b1;
    end
  end

  assign overflow      = overflow_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_count     = pkt_count_q;
endmodule

// File: doc/axis_m_pkt_tx.md
Name: axis_m_pkt_tx

Overview:
- AXI4-Stream master (transmit end) for the 8-bit byte stream consumed by our AXIS slave receivers.
- Local logic pushes bytes and an end-of-packet marker into an internal FIFO.
- The block drains the FIFO onto m_axis_* with full tvalid/tready handshaking, a registered output stage, and tlast on the final byte of each packet.
- Also provides a transmitted-packet counter and a sticky overflow flag.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, at least 4). Each entry holds a 9-bit word: {last, data[7:0]}.
- CNT_W, 16, width of pkt_count.

Ports:
- m_axis_aclk  in  1  clock; all logic on the rising edge.
- m_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  push request for wr_data/wr_last.
- wr_data  in  8  byte to send.
- wr_last  in  1  byte is the last of its packet.
- wr_full  out  1  FIFO full; a push is accepted only when wr_full=0.
- overflow  out  1  sticky: a push was attempted while wr_full=1.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  8  output byte.
- m_axis_tlast  out  1  final byte of the packet.
- busy  out  1  FSM is in SEND.
- pkt_count  out  CNT_W  count of packets completed (tlast beats handshaken).

Behaviour:
- Reset (m_axis_aresetn=0), asynchronous:
  - FIFO pointers and count are cleared; the FIFO is empty.
  - FSM goes to IDLE.
  - m_axis_tvalid=0, m_axis_tdata=8'h00, m_axis_tlast=0.
  - wr_full=0, overflow=0, busy=0, pkt_count=0.
  - Reset mid-packet discards all buffered and in-flight data. No tlast is generated.
- FIFO:
  - Push occurs when wr_en=1 and wr_full=0.
  - wr_full = (count==DEPTH), registered count.
  - A push while wr_full=1 is dropped and sets overflow. This holds even if a pop happens the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Output stage:
  - One register holding tvalid, tdata and tlast.
  - Load condition: the FIFO is non-empty, (tvalid=0 or tready=1), and the FSM permits the load. On load, the FIFO head is popped into the register and tvalid is set.
  - If the register is consumed (tvalid & tready) and no load occurs, tvalid drops to 0 next cycle. tdata/tlast hold their last values.
  - While tvalid=1 and tready=0, tdata and tlast are held stable (AXIS rule). tvalid never deasserts without a handshake.
  - Latency: a push accepted at edge k with the FIFO empty and the register free produces tvalid=1 after edge k+1.
  - Back-to-back operation: with tready held at 1 and the FIFO non-empty, one beat is transferred per cycle.
- FSM, 2 states:
  - IDLE: busy=0. On the edge where the output register loads a beat, go to SEND.
  - SEND: busy=1. Loads are always permitted.
    - On handshake of a beat with tlast=1, go to IDLE unless a new beat loads on the same edge. In that case stay in SEND, because the next packet starts back-to-back.
  - In IDLE, whether a load is permitted depends on the optional feature.
- pkt_count:
  - Increments by 1 on every handshake (tvalid & tready) with tlast=1.
  - Wraps from 2^CNT_W-1 to 0.
- A tready change while tvalid=0 has no effect.

Optional Feature:
- Macro: AXIS_TX_STORE_FWD_EN.
- Defined (store-and-forward):
  - An internal counter pkts_stored tracks the number of complete packets in the FIFO. It increments on a push with wr_last=1 and decrements on a pop of an entry with last=1. A simultaneous increment and decrement leave it unchanged.
  - In IDLE, a load is permitted only if pkts_stored>0, or if wr_full=1 (cut-through fallback for packets longer than DEPTH).
- Undefined (cut-through):
  - In IDLE, a load is permitted whenever the FIFO is non-empty.
  - pkts_stored logic is absent.

Test Plan:
1. Reset, then push 0xA1, 0xA2, 0xA3(last) on consecutive cycles with tready=1:
   - tvalid rises 1 cycle after the first push.
   - Beats A1, A2, A3 are sent on consecutive cycles, with tlast only on A3.
   - pkt_count=1, busy back to 0.
2. Push 4 bytes (last on the 4th) with tready=0 for 5 cycles, then tready=1:
   - tvalid stays high with tdata=first byte held stable throughout the stall.
   - All 4 beats are then sent in order.
3. With tready=0, push 17 bytes (DEPTH=16):
   - 16 bytes enter the FIFO. The output register loads the first byte after its push, so the 17th push is accepted and the FIFO reaches 16.
   - An 18th push sees wr_full=1, is dropped, and sets overflow=1. overflow stays at 1 until reset.
4. Two 2-byte packets {0x10,0x11L},{0x20,0x21L} with tready=1:
   - 4 beats on consecutive cycles; tlast on 0x11 and 0x21.
   - busy stays high across the packet boundary; pkt_count=2.
5. Assert reset while tvalid=1 mid-packet:
   - tvalid, tlast, busy and pkt_count go to 0 immediately (asynchronously).
   - After release, the FIFO is empty and no beat appears without a new push.
6. With AXIS_TX_STORE_FWD_EN, push 3 bytes without last and wait 10 cycles:
   - tvalid stays 0 throughout.
   - After a 4th push with last, tvalid rises the cycle after. Without the macro, tvalid rises 1 cycle after the first push.
